// File: rtl/vga_sound_pkg.sv
// Shared IDs, FSM encoding, default tone constants and counter widths
// for the game sound arbiter.
package vga_sound_pkg;

  // Sound identifiers; the numeric value doubles as the priority.
  typedef enum logic [1:0] {
    SND_NONE   = 2'd0,
    SND_BOUNCE = 2'd1,
    SND_SCORE  = 2'd2,
    SND_MISS   = 2'd3
  } snd_id_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TONE = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Counter widths.
  localparam int HALF_W = 17;  // half-period counter, holds up to 113636
  localparam int PRE_W  = 16;  // 1 ms prescaler
  localparam int DUR_W  = 9;   // duration counter in ms

  // Board defaults for a 50 MHz clk_in.
  localparam int unsigned DEF_TICK_DIV    = 50000;
  localparam int unsigned DEF_BOUNCE_HALF = 28409;
  localparam int unsigned DEF_SCORE_HALF  = 14204;
  localparam int unsigned DEF_MISS1_HALF  = 56818;
  localparam int unsigned DEF_MISS2_HALF  = 113636;
  localparam int unsigned DEF_BOUNCE_MS   = 40;
  localparam int unsigned DEF_SCORE_MS    = 60;
  localparam int unsigned DEF_MISS1_MS    = 150;
  localparam int unsigned DEF_MISS2_MS    = 250;
  localparam int unsigned DEF_GAP_MS      = 10;

  // Pending bit layout: [0] bounce, [1] score, [2] miss.
  function automatic snd_id_t highest_pending(input logic [2:0] pend);
    snd_id_t id;
    if (pend[2])      id = SND_MISS;
    else if (pend[1]) id = SND_SCORE;
    else if (pend[0]) id = SND_BOUNCE;
    else              id = SND_NONE;
    return id;
  endfunction

  function automatic logic [2:0] id_mask(input snd_id_t id);
    logic [2:0] m;
    case (id)
      SND_BOUNCE: m = 3'b001;
      SND_SCORE:  m = 3'b010;
      SND_MISS:   m = 3'b100;
      default:    m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/sound_arbiter_tone_gen.sv
// Loadable half-period square-wave generator. A load restarts the wave low;
// the first toggle then follows exactly half_val enabled cycles later.
module tone_gen
  import vga_sound_pkg::*;
(
  input  logic              clk_in,
  input  logic              reset,
  input  logic              load,
  input  logic [HALF_W-1:0] half_val,
  input  logic              enable,
  input  logic              clr,
  output logic              sq
);

  logic [HALF_W-1:0] r_half_m1;
  logic [HALF_W-1:0] r_cnt;
  logic              r_sq;

  // Half-period down-counter: reload and toggle when it reaches zero.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_half_m1 <= '0;
      r_cnt     <= '0;
      r_sq      <= 1'b0;
    end else if (clr) begin
      r_cnt <= '0;
      r_sq  <= 1'b0;
    end else if (load) begin
      // Counting HALF-1 down to 0 gives a toggle every HALF cycles.
      r_half_m1 <= half_val - HALF_W'(1);
      r_cnt     <= half_val - HALF_W'(1);
      r_sq      <= 1'b0;
    end else if (enable) begin
      if (r_cnt == '0) begin
        r_cnt <= r_half_m1;
        r_sq  <= ~r_sq;
      end else begin
        r_cnt <= r_cnt - HALF_W'(1);
      end
    end
  end

  assign sq = r_sq;

endmodule

// File: rtl/sound_arbiter.sv
// Shares the speaker pin among bounce, score and miss sounds with
// fixed-priority preemption, one-deep pending per requester and a
// silence gap after each completed sound.
module sound_arbiter
  import vga_sound_pkg::*;
#(
  parameter int unsigned TICK_DIV    = DEF_TICK_DIV,
  parameter int unsigned BOUNCE_HALF = DEF_BOUNCE_HALF,
  parameter int unsigned SCORE_HALF  = DEF_SCORE_HALF,
  parameter int unsigned MISS1_HALF  = DEF_MISS1_HALF,
  parameter int unsigned MISS2_HALF  = DEF_MISS2_HALF,
  parameter int unsigned BOUNCE_MS   = DEF_BOUNCE_MS,
  parameter int unsigned SCORE_MS    = DEF_SCORE_MS,
  parameter int unsigned MISS1_MS    = DEF_MISS1_MS,
  parameter int unsigned MISS2_MS    = DEF_MISS2_MS,
  parameter int unsigned GAP_MS      = DEF_GAP_MS
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       req_bounce,
  input  logic       req_score,
  input  logic       req_miss,
  input  logic       mute,
  output logic       speaker,
  output logic       busy,
  output logic [1:0] active_id
);

  // Parameter range checks against the counter widths.
  if (TICK_DIV < 1 || TICK_DIV > (1 << PRE_W)) begin : g_bad_tick
    $error("TICK_DIV does not fit the prescaler");
  end
  if (BOUNCE_HALF < 1 || BOUNCE_HALF > (1 << HALF_W) ||
      SCORE_HALF  < 1 || SCORE_HALF  > (1 << HALF_W) ||
      MISS1_HALF  < 1 || MISS1_HALF  > (1 << HALF_W) ||
      MISS2_HALF  < 1 || MISS2_HALF  > (1 << HALF_W)) begin : g_bad_half
    $error("half-period parameter does not fit the half counter");
  end
  if (BOUNCE_MS < 1 || BOUNCE_MS >= (1 << DUR_W) ||
      SCORE_MS  < 1 || SCORE_MS  >= (1 << DUR_W) ||
      MISS1_MS  < 1 || MISS1_MS  >= (1 << DUR_W) ||
      MISS2_MS  < 1 || MISS2_MS  >= (1 << DUR_W) ||
      GAP_MS    < 1 || GAP_MS    >= (1 << DUR_W)) begin : g_bad_ms
    $error("duration parameter does not fit the duration counter");
  end

  localparam logic [HALF_W-1:0] BOUNCE_HALF_V = HALF_W'(BOUNCE_HALF);
  localparam logic [HALF_W-1:0] SCORE_HALF_V  = HALF_W'(SCORE_HALF);
  localparam logic [HALF_W-1:0] MISS1_HALF_V  = HALF_W'(MISS1_HALF);
  localparam logic [HALF_W-1:0] MISS2_HALF_V  = HALF_W'(MISS2_HALF);
  localparam logic [DUR_W-1:0]  BOUNCE_MS_V   = DUR_W'(BOUNCE_MS);
  localparam logic [DUR_W-1:0]  SCORE_MS_V    = DUR_W'(SCORE_MS);
  localparam logic [DUR_W-1:0]  MISS1_MS_V    = DUR_W'(MISS1_MS);
  localparam logic [DUR_W-1:0]  MISS2_MS_V    = DUR_W'(MISS2_MS);
  localparam logic [DUR_W-1:0]  GAP_MS_V      = DUR_W'(GAP_MS);
  localparam logic [PRE_W-1:0]  TICK_LAST     = PRE_W'(TICK_DIV - 1);

  logic [2:0]        w_req;
  logic [2:0]        w_rise;
  logic [2:0]        r_req_d;
  logic [2:0]        r_pend;
  logic [2:0]        w_pend_clr;
  state_t            r_state;
  state_t            w_state_nxt;
  snd_id_t           r_active;
  snd_id_t           w_active_nxt;
  snd_id_t           w_top;
  logic [DUR_W-1:0]  r_dur;
  logic [DUR_W-1:0]  w_dur_nxt;
  logic              r_note2;
  logic              w_note2_nxt;
  logic [PRE_W-1:0]  r_pre;
  logic              w_tick;
  logic              w_pre_clr;
  logic              w_start;
  logic [HALF_W-1:0] w_start_half;
  logic [DUR_W-1:0]  w_start_dur;
  logic              w_tone_load;
  logic              w_tone_clr;
  logic [HALF_W-1:0] w_tone_half;
  logic              w_spk;

  assign w_req  = {req_miss, req_score, req_bounce};
  assign w_rise = w_req & ~r_req_d;
  assign w_top  = highest_pending(r_pend);
  assign w_tick = (r_state != IDLE) && (r_pre == TICK_LAST);

  // Rising-edge detect on the request inputs.
  // NOTE: reset to 1 so a request already high at reset release is not seen as a new edge.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) r_req_d <= 3'b111;
    else       r_req_d <= w_req;
  end

  // One-deep pending flags: set on a rise, cleared when that sound starts.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) r_pend <= 3'b000;
    else       r_pend <= (r_pend & ~w_pend_clr) | w_rise;
  end

  // 1 ms prescaler; restarted whenever a sound starts, idle while IDLE.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset)                r_pre <= '0;
    else if (w_pre_clr)       r_pre <= '0;
    else if (r_state != IDLE) r_pre <= w_tick ? '0 : r_pre + PRE_W'(1);
  end

  // Start parameters for the highest pending sound.
  always_comb begin
    w_start_half = '0;
    w_start_dur  = '0;
    case (w_top)
      SND_BOUNCE: begin w_start_half = BOUNCE_HALF_V; w_start_dur = BOUNCE_MS_V; end
      SND_SCORE:  begin w_start_half = SCORE_HALF_V;  w_start_dur = SCORE_MS_V;  end
      SND_MISS:   begin w_start_half = MISS1_HALF_V;  w_start_dur = MISS1_MS_V;  end
      default:    ;
    endcase
  end

  // FSM next state, arbitration and tone-generator control.
  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt  = r_state;
    w_active_nxt = r_active;
    w_dur_nxt    = r_dur;
    w_note2_nxt  = r_note2;
    w_start      = 1'b0;
    w_pre_clr    = 1'b0;
    w_tone_load  = 1'b0;
    w_tone_clr   = 1'b0;
    w_tone_half  = '0;
    w_pend_clr   = 3'b000;

    unique case (r_state)
      IDLE: begin
        if (w_top != SND_NONE) w_start = 1'b1;
      end
      TONE: begin
        if (w_top > r_active) begin
          // Strictly higher priority preempts; the current sound is dropped.
          w_start = 1'b1;
        end else if (w_tick && r_dur == DUR_W'(1)) begin
          if (r_active == SND_MISS && !r_note2) begin
            w_note2_nxt = 1'b1;
            w_dur_nxt   = MISS2_MS_V;
            w_tone_load = 1'b1;
            w_tone_half = MISS2_HALF_V;
          end else begin
            w_note2_nxt  = 1'b0;
            w_active_nxt = SND_NONE;
            w_dur_nxt    = GAP_MS_V;
            w_tone_clr   = 1'b1;
            w_state_nxt  = GAP;
          end
        end else if (w_tick) begin
          w_dur_nxt = r_dur - DUR_W'(1);
        end
      end
      GAP: begin
        // Pending sounds never shorten the gap.
        if (w_tick) begin
          if (r_dur == DUR_W'(1)) begin
            w_dur_nxt   = '0;
            w_state_nxt = IDLE;
          end else begin
            w_dur_nxt = r_dur - DUR_W'(1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_start) begin
      w_state_nxt  = TONE;
      w_active_nxt = w_top;
      w_dur_nxt    = w_start_dur;
      w_note2_nxt  = 1'b0;
      w_pre_clr    = 1'b1;
      w_tone_load  = 1'b1;
      w_tone_clr   = 1'b0;
      w_tone_half  = w_start_half;
      w_pend_clr   = id_mask(w_top);
    end
  end

  // FSM and sound-tracking registers.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_active <= SND_NONE;
      r_dur    <= '0;
      r_note2  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_active <= w_active_nxt;
      r_dur    <= w_dur_nxt;
      r_note2  <= w_note2_nxt;
    end
  end

  tone_gen u_tone_gen (
    .clk_in   (clk_in),
    .reset    (reset),
    .load     (w_tone_load),
    .half_val (w_tone_half),
    .enable   (r_state == TONE),
    .clr      (w_tone_clr),
    .sq       (w_spk)
  );

  assign speaker   = w_spk & ~mute;
  assign busy      = (r_state != IDLE) | (|r_pend);
  assign active_id = r_active;

endmodule

// File: tb/tb_sound_arbiter.sv
// Directed bench for sound_arbiter with shortened timing: expected
// active_id/busy transitions are queued with their cycle numbers when the
// stimulus is driven and compared by a monitor as the DUT changes them.
module tb_sound_arbiter;

  logic       clk_in = 1'b0;
  logic       reset;
  logic       req_bounce, req_score, req_miss, mute;
  logic       speaker, busy;
  logic [1:0] active_id;

  int cyc   = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int val;
    int cyc;
  } ev_t;

  ev_t        q_act[$];
  ev_t        q_busy[$];
  logic       mon_en = 1'b0;
  logic [1:0] prev_act;
  logic       prev_busy;

  sound_arbiter #(
    .TICK_DIV    (10),
    .BOUNCE_HALF (3),
    .SCORE_HALF  (2),
    .MISS1_HALF  (5),
    .MISS2_HALF  (7),
    .BOUNCE_MS   (4),
    .SCORE_MS    (4),
    .MISS1_MS    (4),
    .MISS2_MS    (4),
    .GAP_MS      (2)
  ) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .req_bounce (req_bounce),
    .req_score  (req_score),
    .req_miss   (req_miss),
    .mute       (mute),
    .speaker    (speaker),
    .busy       (busy),
    .active_id  (active_id)
  );

  always #10 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_act(input int v, input int c);
    ev_t e;
    e.val = v;
    e.cyc = c;
    q_act.push_back(e);
  endtask

  task automatic push_busy(input int v, input int c);
    ev_t e;
    e.val = v;
    e.cyc = c;
    q_busy.push_back(e);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk_in);
  endtask

  // which: 0 bounce, 1 score, 2 miss
  task automatic pulse(input int which);
    case (which)
      0:       req_bounce = 1'b1;
      1:       req_score  = 1'b1;
      default: req_miss   = 1'b1;
    endcase
    @(negedge clk_in);
    req_bounce = 1'b0;
    req_score  = 1'b0;
    req_miss   = 1'b0;
  endtask

  // Every change of active_id / busy must match the next queued event.
  always @(negedge clk_in) begin : mon
    ev_t e;
    if (mon_en) begin
      if (active_id !== prev_act) begin
        if (q_act.size() != 0) e = q_act.pop_front();
        else begin e.val = int'(prev_act); e.cyc = -1; end
        check("active_id_val", active_id, e.val);
        check("active_id_cyc", cyc, e.cyc);
        prev_act = active_id;
      end
      if (busy !== prev_busy) begin
        if (q_busy.size() != 0) e = q_busy.pop_front();
        else begin e.val = int'(prev_busy); e.cyc = -1; end
        check("busy_val", busy, e.val);
        check("busy_cyc", cyc, e.cyc);
        prev_busy = busy;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, s, m;
    reset = 1'b1;
    req_bounce = 1'b0;
    req_score  = 1'b0;
    req_miss   = 1'b0;
    mute       = 1'b0;
    repeat (3) @(negedge clk_in);
    check("rst_speaker", speaker, 0);
    check("rst_busy", busy, 0);
    check("rst_active", active_id, 0);
    #2 reset = 1'b0;
    prev_act  = active_id;
    prev_busy = busy;
    mon_en    = 1'b1;

    // 1: single bounce, half 3, 40-cycle tone, 20-cycle gap
    wait_to(cyc + 5);
    n = cyc; s = n + 2;
    push_busy(1, n + 1); push_act(1, s); push_act(0, s + 40); push_busy(0, s + 60);
    pulse(0);
    wait_to(s);
    for (int k = 0; k < 40; k++) begin
      check("bounce_spk", speaker, (k / 3) % 2);
      @(negedge clk_in);
    end
    check("bounce_end_spk", speaker, 0);
    wait_to(s + 70);

    // 2: miss and bounce together; miss both notes, gap, then bounce
    n = cyc; s = n + 2;
    push_busy(1, n + 1); push_act(3, s); push_act(0, s + 80);
    push_act(1, s + 101); push_act(0, s + 141); push_busy(0, s + 161);
    req_miss = 1'b1; req_bounce = 1'b1;
    @(negedge clk_in);
    req_miss = 1'b0; req_bounce = 1'b0;
    wait_to(s);
    for (int k = 0; k < 80; k++) begin
      check("miss_spk", speaker, (k < 40) ? (k / 5) % 2 : ((k - 40) / 7) % 2);
      @(negedge clk_in);
    end
    check("miss_gap_spk", speaker, 0);
    wait_to(s + 170);

    // 3: score preempts bounce mid-tone, bounce never resumes
    n = cyc; s = n + 2;
    push_busy(1, n + 1); push_act(1, s);
    pulse(0);
    wait_to(s + 10);
    m = cyc;
    push_act(2, m + 2); push_act(0, m + 42); push_busy(0, m + 62);
    pulse(1);
    wait_to(m + 2);
    for (int k = 0; k < 40; k++) begin
      check("preempt_spk", speaker, (k / 2) % 2);
      @(negedge clk_in);
    end
    wait_to(m + 80);

    // 4: two bounce pulses during score -> exactly one bounce afterwards
    n = cyc; s = n + 2;
    push_busy(1, n + 1); push_act(2, s); push_act(0, s + 40);
    push_act(1, s + 61); push_act(0, s + 101); push_busy(0, s + 121);
    pulse(1);
    wait_to(s + 5);
    pulse(0);
    wait_to(s + 15);
    pulse(0);
    wait_to(s + 140);

    // 5: muted miss keeps speaker low with unchanged timing
    mute = 1'b1;
    n = cyc; s = n + 2;
    push_busy(1, n + 1); push_act(3, s); push_act(0, s + 80); push_busy(0, s + 100);
    pulse(2);
    wait_to(s);
    for (int k = 0; k < 80; k++) begin
      check("mute_spk", speaker, 0);
      @(negedge clk_in);
    end
    wait_to(s + 110);
    mute = 1'b0;

    // 6: request held high through reset release does not trigger
    wait_to(cyc + 2);
    #2 reset = 1'b1; req_miss = 1'b1;
    wait_to(cyc + 3);
    #2 reset = 1'b0;
    wait_to(cyc + 30);
    check("hold_busy", busy, 0);
    check("hold_active", active_id, 0);
    req_miss = 1'b0;
    wait_to(cyc + 5);
    check("hold_busy_after", busy, 0);

    // 7: reset mid-tone clears outputs at once and drops the pending bounce
    n = cyc; s = n + 2;
    push_busy(1, n + 1); push_act(1, s);
    pulse(0);
    wait_to(s + 5);
    pulse(0);
    wait_to(s + 10);
    check("pre_rst_spk", speaker, 1);
    push_act(0, s + 11); push_busy(0, s + 11);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_spk", speaker, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_active", active_id, 0);
    wait_to(s + 13);
    #2 reset = 1'b0;
    wait_to(s + 60);
    check("post_rst_busy", busy, 0);
    check("post_rst_active", active_id, 0);

    wait_to(cyc + 5);
    check("act_events_left", q_act.size(), 0);
    check("busy_events_left", q_busy.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
